// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant 1 cycle after request, start/ack 1 cycle later.
// Owner holds the grant for a whole packet; other requesters wait; watchdog frees a stuck transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_last,
  input  logic [NUM_REQ*8-1:0] i_byte,
  input  logic                 i_tx_done,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_byte,
  output logic                 o_timeout,
  output logic                 o_busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t               state, state_d;
  logic [PW-1:0]        ptr, ptr_d;
  logic [PW-1:0]        owner, owner_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   grant_d, ack_d;
  logic                 start_d, timeout_d, busy_d;
  logic [7:0]           byte_d;
  logic                 rel_g;

  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        scan_idx;

  // Lowest requester index at or after ptr, wrapping at NUM_REQ
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && i_req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    owner_d   = owner;
    cnt_d     = cnt;
    last_d    = last_q;
    grant_d   = o_grant;
    ack_d     = '0;
    start_d   = 1'b0;
    byte_d    = o_tx_byte;
    timeout_d = 1'b0;
    rel_g     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (i_req[owner]) begin
          byte_d  = i_byte[{owner, 3'b000} +: 8];
          last_d  = i_last[owner];
          ack_d   = o_grant;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          rel_g = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt + CW'(1);
        // A done on the terminal count still wins over the watchdog
        if (i_tx_done) begin
          if (last_q) rel_g = 1'b1;
          else        state_d = LOAD;
        end else if (cnt == CNT_END) begin
          timeout_d = 1'b1;
          rel_g     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel_g) begin
      grant_d = '0;
      ptr_d   = (owner == LAST_IDX) ? '0 : owner + PW'(1);
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      last_q     <= 1'b0;
      o_grant    <= '0;
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      owner      <= owner_d;
      cnt        <= cnt_d;
      last_q     <= last_d;
      o_grant    <= grant_d;
      o_ack      <= ack_d;
      o_tx_start <= start_d;
      o_tx_byte  <= byte_d;
      o_timeout  <= timeout_d;
      o_busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level model checked every cycle on a long-timeout instance,
// plus a short-timeout instance exercised with directed watchdog checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TA = 131072;
  localparam int TB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [3:0]  i_req, i_last, o_grant, o_ack;
  logic [31:0] i_byte;
  logic        i_tx_done, o_tx_start, o_timeout, o_busy;
  logic [7:0]  o_tx_byte;

  logic [3:0]  b_req, b_last, b_grant, b_ack;
  logic [31:0] b_byte;
  logic        b_done, b_start, b_timeout, b_busy;
  logic [7:0]  b_tx_byte;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TA)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_last(i_last), .i_byte(i_byte),
    .i_tx_done(i_tx_done), .o_grant(o_grant), .o_ack(o_ack), .o_tx_start(o_tx_start),
    .o_tx_byte(o_tx_byte), .o_timeout(o_timeout), .o_busy(o_busy));

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TB)) dut_wd (
    .clk(clk), .reset(reset), .i_req(b_req), .i_last(b_last), .i_byte(b_byte),
    .i_tx_done(b_done), .o_grant(b_grant), .o_ack(b_ack), .o_tx_start(b_start),
    .o_tx_byte(b_tx_byte), .o_timeout(b_timeout), .o_busy(b_busy));

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (nprint < 40) begin
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        nprint++;
      end
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (v[k]) r = (r < 0) ? k : 99;
    return r;
  endfunction

  // Requester byte queues
  logic [7:0] qb [4][32];
  logic       ql [4][32];
  int         head [4];
  int         tail [4];

  task automatic push(input int k, input logic [7:0] b, input logic l);
    qb[k][tail[k]] = b;
    ql[k][tail[k]] = l;
    tail[k]++;
  endtask

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < 4; k++) if (head[k] < tail[k]) e = 1'b0;
    return e;
  endfunction

  // Requesters: pop on ack, present next byte; idle lanes carry noise
  initial begin
    i_req = '0; i_last = '0; i_byte = '0;
    for (int k = 0; k < 4; k++) begin head[k] = 0; tail[k] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (o_ack[k] && head[k] < tail[k]) head[k]++;
        if (head[k] < tail[k]) begin
          i_req[k]         = 1'b1;
          i_byte[8*k +: 8] = qb[k][head[k]];
          i_last[k]        = ql[k][head[k]];
        end else begin
          i_req[k]         = 1'b0;
          i_byte[8*k +: 8] = 8'($urandom);
          i_last[k]        = 1'($urandom);
        end
      end
    end
  end

  // Transmitter: done pulse tx_delay cycles after each start
  int cd, tx_delay;
  initial begin
    i_tx_done = 1'b0; cd = 0;
    forever begin
      @(posedge clk); #1;
      i_tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) i_tx_done = 1'b1;
      end
      if (o_tx_start) cd = tx_delay;
    end
  end

  // Packet-level model: who owns the transmitter, whether a frame is in flight, how long it has waited
  int         m_owner, m_ptr, m_waited;
  bit         m_inflight, m_last, m_valid;
  logic [3:0] e_grant, e_ack;
  logic       e_start, e_timeout, e_busy;
  logic [7:0] e_byte;

  task automatic model_step();
    bit give_up, found;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_waited = 0; m_inflight = 0; m_last = 0;
      e_grant = '0; e_ack = '0; e_start = 0; e_timeout = 0; e_busy = 0; e_byte = 8'h00;
      m_valid = 1;
    end else if (m_valid) begin
      give_up = 0; e_ack = '0; e_start = 0; e_timeout = 0;
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < NR; k++)
          if (!found && i_req[(m_ptr + k) % NR]) begin found = 1; m_owner = (m_ptr + k) % NR; end
        if (found) begin e_grant = 4'(1 << m_owner); m_inflight = 0; end
      end else if (!m_inflight) begin
        if (i_req[m_owner]) begin
          e_byte = i_byte[8*m_owner +: 8]; m_last = i_last[m_owner];
          e_ack = 4'(1 << m_owner); e_start = 1; m_inflight = 1; m_waited = 0;
        end else give_up = 1;
      end else begin
        if (i_tx_done) begin
          if (m_last) give_up = 1; else m_inflight = 0;
        end else if (m_waited == TA - 1) begin
          e_timeout = 1; give_up = 1;
        end else m_waited++;
      end
      if (give_up) begin
        e_grant = '0; m_ptr = (m_owner + 1) % NR; m_owner = -1; m_inflight = 0;
      end
      e_busy = (m_owner >= 0);
    end
  endtask

  initial begin
    m_valid = 0;
    forever begin @(posedge clk); model_step(); end
  end

  // The compare process
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("grant", o_grant, e_grant);
        chk("ack", o_ack, e_ack);
        chk("tx_start", o_tx_start, e_start);
        chk("tx_byte", o_tx_byte, e_byte);
        chk("timeout", o_timeout, e_timeout);
        chk("busy", o_busy, e_busy);
      end
    end
  end

  // Log of frames sent, grant order and ack pulses
  int sent_b [256];
  int sent_w [256];
  int gseq   [64];
  int n_sent, n_g;
  int ack_cnt [4];
  logic [3:0] prev_grant;
  initial begin
    n_sent = 0; n_g = 0; prev_grant = '0;
    for (int k = 0; k < 256; k++) begin sent_b[k] = -1; sent_w[k] = -1; end
    for (int k = 0; k < 64; k++) gseq[k] = -1;
    for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
    forever begin
      @(negedge clk);
      if (o_tx_start === 1'b1 && n_sent < 256) begin
        sent_b[n_sent] = int'(o_tx_byte); sent_w[n_sent] = oh2i(o_grant); n_sent++;
      end
      if (o_grant != '0 && prev_grant == '0 && n_g < 64) begin gseq[n_g] = oh2i(o_grant); n_g++; end
      for (int k = 0; k < 4; k++) if (o_ack[k] === 1'b1) ack_cnt[k]++;
      prev_grant = o_grant;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n;
    bit ok;
    n = 0; ok = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      ok = (o_busy === 1'b0) && queues_empty();
    end
    chk({name, "_idle_in_budget"}, ok, 1);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic check_frames(input string name, input int base, input int cnt,
                              input int bytes [8], input int who [8]);
    chk({name, "_nframes"}, n_sent - base, cnt);
    for (int k = 0; k < cnt; k++) begin
      chk($sformatf("%s_byte%0d", name, k), sent_b[base + k], bytes[k]);
      chk($sformatf("%s_who%0d", name, k), sent_w[base + k], who[k]);
    end
  endtask

  initial begin
    int base, gb, a2, a1, n;
    int eb [8];
    int ew [8];
    reset = 1'b1; tx_delay = 20;
    b_req = '0; b_last = '0; b_byte = '0; b_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", o_grant, 4'b0000);
    chk("rst_ack", o_ack, 4'b0000);
    chk("rst_start", o_tx_start, 1'b0);
    chk("rst_byte", o_tx_byte, 8'h00);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    cyc(); reset = 1'b0;

    // Single packet from requester 2
    @(negedge clk);
    base = n_sent; gb = n_g; a2 = ack_cnt[2];
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    wait_idle(400, "t1");
    eb = '{8'h41, 8'h42, 8'h43, 0, 0, 0, 0, 0};
    ew = '{2, 2, 2, 0, 0, 0, 0, 0};
    check_frames("t1", base, 3, eb, ew);
    chk("t1_acks", ack_cnt[2] - a2, 3);
    chk("t1_grants", n_g - gb, 1);
    chk("t1_grant0", gseq[gb], 2);

    // Round robin, all requesters busy, fresh pointer
    cyc(); reset = 1'b1; cyc(); reset = 1'b0;
    @(negedge clk);
    tx_delay = 6; base = n_sent; gb = n_g;
    for (int k = 0; k < 4; k++) begin push(k, 8'(8'h10 + k), 1'b1); push(k, 8'(8'h20 + k), 1'b1); end
    wait_idle(600, "t2");
    eb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    ew = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_frames("t2", base, 8, eb, ew);
    for (int k = 0; k < 8; k++) chk($sformatf("t2_grant%0d", k), gseq[gb + k], ew[k]);

    // Packet lock: 1 sends four bytes, 0 and 3 arrive mid-packet
    @(negedge clk);
    base = n_sent; gb = n_g; a1 = ack_cnt[1];
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b0); push(1, 8'h54, 1'b1);
    n = 0;
    while (ack_cnt[1] == a1 && n < 100) begin @(negedge clk); n++; end
    chk("t3_first_ack", ack_cnt[1] - a1, 1);
    push(0, 8'h0A, 1'b1); push(3, 8'h3A, 1'b1);
    wait_idle(600, "t3");
    eb = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h3A, 8'h0A, 0, 0};
    ew = '{1, 1, 1, 1, 3, 0, 0, 0};
    check_frames("t3", base, 6, eb, ew);
    chk("t3_grant0", gseq[gb], 1);
    chk("t3_grant1", gseq[gb + 1], 3);
    chk("t3_grant2", gseq[gb + 2], 0);

    // Abandon after a non-last byte
    @(negedge clk);
    base = n_sent; gb = n_g;
    push(2, 8'h77, 1'b0);
    wait_idle(200, "t4");
    eb = '{8'h77, 0, 0, 0, 0, 0, 0, 0};
    ew = '{2, 0, 0, 0, 0, 0, 0, 0};
    check_frames("t4", base, 1, eb, ew);
    chk("t4_grant0", gseq[gb], 2);
    repeat (30) @(negedge clk);
    chk("t4_no_extra_start", n_sent - base, 1);

    // Reset mid-WAIT, stray done afterwards
    tx_delay = 20; base = n_sent;
    push(3, 8'h90, 1'b0); push(3, 8'h91, 1'b1);
    n = 0;
    while (n_sent == base && n < 50) begin @(negedge clk); n++; end
    chk("t5_started", n_sent - base, 1);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) head[k] = tail[k];
    cyc(); reset = 1'b1; cyc(); reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_grant", o_grant, 4'b0000);
    chk("t5_rst_start", o_tx_start, 1'b0);
    chk("t5_rst_byte", o_tx_byte, 8'h00);
    chk("t5_rst_busy", o_busy, 1'b0);
    base = n_sent; gb = n_g;
    repeat (25) @(negedge clk);
    chk("t5_stray_ignored", n_sent - base, 0);
    chk("t5_stray_idle", o_busy, 1'b0);
    push(0, 8'hB0, 1'b1); push(3, 8'hB3, 1'b1);
    wait_idle(300, "t5");
    eb = '{8'hB0, 8'hB3, 0, 0, 0, 0, 0, 0};
    ew = '{0, 3, 0, 0, 0, 0, 0, 0};
    check_frames("t5", base, 2, eb, ew);
    chk("t5_grant0", gseq[gb], 0);

    // Watchdog instance: timeout after 16 cycles, then done on the terminal count
    cyc();
    b_byte = 32'h0000_A500; b_last = 4'b0010; b_req = 4'b0010;
    n = 0;
    while (b_start !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("wd_start_latency", n, 2);
    chk("wd_byte", b_tx_byte, 8'hA5);
    chk("wd_ack", b_ack, 4'b0010);
    b_req = '0;
    n = 0;
    while (b_timeout !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("wd_timeout_after", n, TB);
    chk("wd_grant_released", b_grant, 4'b0000);
    chk("wd_busy", b_busy, 1'b0);
    cyc();
    chk("wd_timeout_one_cycle", b_timeout, 1'b0);
    b_byte = 32'h00C3_5A00; b_last = 4'b0110; b_req = 4'b0110;
    n = 0;
    while (b_start !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("wd_ptr_advanced", b_grant, 4'b0100);
    chk("wd_byte2", b_tx_byte, 8'hC3);
    b_req = 4'b0010;
    repeat (14) cyc();
    cyc(); b_done = 1'b1;
    cyc(); b_done = 1'b0;
    chk("wd_done_beats_timeout", b_timeout, 1'b0);
    chk("wd_done_release", b_grant, 4'b0000);
    cyc();
    chk("wd_no_late_timeout", b_timeout, 1'b0);
    chk("wd_next_owner", b_grant, 4'b0010);
    b_req = '0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-stream requesters. A requester holds the grant for a whole packet, from its first byte through the byte flagged last. The block sequences one byte at a time into the transmitter and waits for the frame-complete pulse before loading the next byte. A watchdog releases the grant if the transmitter never reports completion.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 131072: maximum number of cycles to wait for i_tx_done after a start pulse.
- clk, in, 1: system clock, rising edge.
- reset, in, 1: one clock; reset is synchronous and active-high.
- i_req, in, NUM_REQ: per-requester byte valid; held high until the matching o_ack.
- i_last, in, NUM_REQ: per-requester flag marking the presented byte as the last byte of the packet.
- i_byte, in, NUM_REQ*8: packed bytes; requester k uses bits [8k+7:8k].
- i_tx_done, in, 1: one-cycle pulse from the transmitter when its stop bit completes.
- o_grant, out, NUM_REQ: one-hot current owner; all zero when no requester owns the transmitter.
- o_ack, out, NUM_REQ: one-cycle pulse to the owner meaning its byte was accepted.
- o_tx_start, out, 1: one-cycle pulse telling the transmitter to begin a frame.
- o_tx_byte, out, 8: byte for the transmitter; held until the next load.
- o_timeout, out, 1: one-cycle pulse when the watchdog expires.
- o_busy, out, 1: high whenever the state is not IDLE.

## Operation
- There are three states: IDLE, LOAD and WAIT. All outputs are registered.
- Priority pointer ptr:
  - Width is $clog2(NUM_REQ) bits; reset value is 0.
  - The search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1, so the lowest index at or after ptr wins.
- IDLE:
  - If any i_req is high, the chosen requester's o_grant bit is set next cycle and the state moves to LOAD.
  - Otherwise the block stays in IDLE.
- LOAD:
  - If i_req of the owner is high, the block captures that requester's i_byte into o_tx_byte and latches its i_last into last_q.
  - In the same capture it pulses o_ack of the owner and o_tx_start, both for one cycle (next cycle), and moves to WAIT.
  - If i_req of the owner is low (requester abandoned the packet), the grant is released.
- WAIT:
  - Watchdog counter cnt is cleared on entry and increments every cycle.
  - On i_tx_done with last_q=0, the state returns to LOAD and the same owner keeps the grant.
  - On i_tx_done with last_q=1, the grant is released.
  - If cnt reaches TIMEOUT_CYCLES-1 without i_tx_done, the block pulses o_timeout and releases the grant.
- Grant release:
  - o_grant is cleared, ptr is set to owner+1 modulo NUM_REQ, and the state goes to IDLE.
  - Release happens from LOAD, from WAIT on done, or from WAIT on timeout.
- Width rules:
  - cnt is $clog2(TIMEOUT_CYCLES+1) bits wide.
  - ptr wraps from NUM_REQ-1 to 0.
- Boundary conditions:
  - i_tx_done arriving in IDLE or LOAD is ignored.
  - i_tx_done in the same cycle cnt reaches its terminal value counts as done; o_timeout stays low.
  - Requests from non-owners during a packet are ignored; they are served when the grant is released, in round-robin order.
  - Changes to i_req, i_last or i_byte on non-owners never affect the outputs.
- Reset mid-operation:
  - Next cycle, all outputs are 0, ptr=0, cnt=0, last_q=0 and the state is IDLE.
  - A frame already started in the transmitter is not aborted; a late i_tx_done after reset is ignored.

## Timing
- Reset values: o_grant=0, o_ack=0, o_tx_start=0, o_tx_byte=8'h00, o_timeout=0, o_busy=0.
- Request to start: i_req rises in cycle N with the block in IDLE. o_grant is set in N+1 (LOAD), and o_ack and o_tx_start pulse in N+2.
- Byte to byte within a packet: i_tx_done in cycle M gives LOAD in M+1 and o_tx_start in M+2.
- End of packet: done on the last byte in cycle M gives o_grant=0 in M+1. The next owner's grant appears in M+2 at the earliest.
- Requester handshake:
  - i_byte and i_last must be stable while i_req is high and the requester is granted.
  - The requester may present its next byte the cycle after o_ack; the block does not sample it again before the next LOAD.
- o_ack and o_tx_start are always coincident and never longer than one cycle.
- Timeout: o_timeout pulses exactly TIMEOUT_CYCLES cycles after the cycle in which o_tx_start was high.

## Test plan
- Single packet:
  - Stimulus: requester 2 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43); the transmitter model returns i_tx_done 20 cycles after each start.
  - Required: three o_tx_start pulses with bytes in order, three o_ack[2] pulses, and o_grant=4'b0100 throughout, cleared one cycle after the third done.
- Round-robin:
  - Stimulus: all 4 requesters send 1-byte packets continuously.
  - Required: grant order 0, 1, 2, 3, 0 and no requester is served twice before the others.
- Packet lock:
  - Stimulus: requester 1 sends a 4-byte packet while requester 0 raises i_req mid-packet.
  - Required: all 4 bytes of requester 1 go out back-to-back, then requester 2 or 3 if pending, otherwise 0.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16 and no i_tx_done.
  - Required: o_timeout pulses 16 cycles after o_tx_start, the grant releases and ptr advances.
  - Also: done and timeout in the same cycle produce no o_timeout.
- Abandon:
  - Stimulus: the owner drops i_req after its first non-last byte completes.
  - Required: LOAD releases the grant, with no extra o_tx_start.
- Reset mid-WAIT:
  - Stimulus: assert reset for one cycle mid-WAIT.
  - Required: next cycle all outputs are 0; a stray i_tx_done is then ignored; the next request grants requester 0 first.
